lfsr_checker: RTL and testbench

- Receive-side companion of the team's parameterised Fibonacci XNOR LFSR pattern generator.
- Takes the generator's serial bit stream (the new LSB shifted in each step) and self-synchronises a local LFSR to it.
- Declares lock once synchronised, then counts bit errors against the free-running local prediction.
- Sits at the far end of a link/BIST path for PRBS integrity and BER checking.

---
 rtl/lfsr_pkg.sv | 30 +++
 rtl/lfsr_checker_if.sv | 56 +++++
 rtl/lfsr_chk_fsm.sv | 81 ++++++++
 rtl/lfsr_checker.sv | 105 ++++++++++
 tb/tb_lfsr_checker.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the Fibonacci XNOR LFSR generator and checker:
// supported length range, checker state encoding and the tap table.
package lfsr_pkg;

  localparam int LFSR_N_MIN = 3;
  localparam int LFSR_N_MAX = 10;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Tap mask for an N-bit register; only bits [N-1:0] are meaningful.
  // Unsupported lengths return an empty mask.
  function automatic logic [LFSR_N_MAX-1:0] lfsr_taps(input int n);
    case (n)
      3:       return 10'b00_0000_0110;
      4:       return 10'b00_0000_1100;
      5:       return 10'b00_0001_0100;
      6:       return 10'b00_0011_0000;
      7:       return 10'b00_0110_0000;
      8:       return 10'b00_1011_1000;
      9:       return 10'b01_0001_0000;
      10:      return 10'b10_0100_0000;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Link-side bundle of the PRBS checker: serial input, qualifier, clear and status.
// With LFSR_CHK_BITCNT_EN defined the bundle also carries the locked-bit count.
interface lfsr_checker_if #(
  parameter int ERR_W = 16
);

  logic             din;
  logic             din_valid;
  logic             err_clr;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

`ifdef LFSR_CHK_BITCNT_EN
  logic [31:0]      bit_cnt;

  modport master (
    output din,
    output din_valid,
    output err_clr,
    input  locked,
    input  err,
    input  err_cnt,
    input  bit_cnt
  );

  modport slave (
    input  din,
    input  din_valid,
    input  err_clr,
    output locked,
    output err,
    output err_cnt,
    output bit_cnt
  );
`else
  modport master (
    output din,
    output din_valid,
    output err_clr,
    input  locked,
    input  err,
    input  err_cnt
  );

  modport slave (
    input  din,
    input  din_valid,
    input  err_clr,
    output locked,
    output err,
    output err_cnt
  );
`endif

endinterface

// File: rtl/lfsr_chk_fsm.sv
// Synchronisation controller of the PRBS checker: seed/verify/locked sequencing
// with the seed, consecutive-match and consecutive-miss counters.
module lfsr_chk_fsm
  import lfsr_pkg::*;
#(
  parameter int N        = 8,
  parameter int LOCK_THR = 16,
  parameter int LOSS_THR = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       match,
  input  logic       all_ones,
  output chk_state_t state,
  output logic       locked
);

  logic [7:0] seed_cnt;
  logic [7:0] match_cnt;
  logic [7:0] miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEED;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
    end else if (adv) begin
      case (state)
        SEED: begin
          if (seed_cnt == 8'(N - 1)) begin
            state     <= VERIFY;
            seed_cnt  <= '0;
            match_cnt <= '0;
          end else begin
            seed_cnt <= seed_cnt + 8'd1;
          end
        end

        // All-ones is the XNOR lockup state: a stuck-high line predicts itself.
        VERIFY: begin
          if (match && !all_ones) begin
            if (match_cnt == 8'(LOCK_THR - 1)) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + 8'd1;
            end
          end else begin
            match_cnt <= '0;
          end
        end

        LOCKED: begin
          if (!match) begin
            if (miss_cnt == 8'(LOSS_THR - 1)) begin
              state    <= SEED;
              locked   <= 1'b0;
              seed_cnt <= '0;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + 8'd1;
            end
          end else begin
            miss_cnt <= '0;
          end
        end

        default: begin
          state  <= SEED;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker for the Fibonacci XNOR LFSR generator.
// Optional macro LFSR_CHK_BITCNT_EN adds a saturating count of bits received while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int N        = 8,
  parameter int LOCK_THR = 16,
  parameter int LOSS_THR = 8,
  parameter int ERR_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  lfsr_checker_if.slave link
);

  localparam logic [LFSR_N_MAX-1:0] TAP_MASK = lfsr_taps(N);
  localparam logic [N-1:0]          TAPS     = TAP_MASK[N-1:0];

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  logic [N-1:0]     chk_reg;
  logic             adv;
  logic             pred;
  logic             match;
  logic             all_ones;
  logic             shift_in;
  logic             bit_err;
  chk_state_t       state;
  logic             locked;
  logic             err_p1;
  logic [ERR_W-1:0] err_cnt_p1;

  assign adv      = link.din_valid;
  assign pred     = ~^(chk_reg & TAPS);
  assign match    = (link.din == pred);
  assign all_ones = &chk_reg;
  assign bit_err  = adv && (state == LOCKED) && !match;

  // Once locked the local LFSR free-runs so a line error cannot corrupt it.
  assign shift_in = (state == LOCKED) ? pred : link.din;

  lfsr_chk_fsm #(
    .N        (N),
    .LOCK_THR (LOCK_THR),
    .LOSS_THR (LOSS_THR)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv),
    .match    (match),
    .all_ones (all_ones),
    .state    (state),
    .locked   (locked)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_reg <= '0;
    end else if (adv) begin
      chk_reg <= {chk_reg[N-2:0], shift_in};
    end
  end

  // Stage p1: error pulse and counter, one cycle after the offending bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_p1     <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      err_p1 <= bit_err;
      if (link.err_clr) begin
        err_cnt_p1 <= '0;
      end else if (bit_err) begin
        err_cnt_p1 <= sat_inc_err(err_cnt_p1);
      end
    end
  end

  assign link.locked  = locked;
  assign link.err     = err_p1;
  assign link.err_cnt = err_cnt_p1;

`ifdef LFSR_CHK_BITCNT_EN
  function automatic logic [31:0] sat_inc_bits(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0] bit_cnt_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_p1 <= '0;
    end else if (link.err_clr) begin
      bit_cnt_p1 <= '0;
    end else if (adv && (state == LOCKED)) begin
      bit_cnt_p1 <= sat_inc_bits(bit_cnt_p1);
    end
  end

  assign link.bit_cnt = bit_cnt_p1;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: N=8 main instance, an ERR_W=4 twin on the same
// stream, and one instance per supported N fed by a bench-side generator.
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_checker_if #(.ERR_W(16)) link ();
  lfsr_checker_if #(.ERR_W(4))  link4 ();

  assign link4.din       = link.din;
  assign link4.din_valid = link.din_valid;
  assign link4.err_clr   = link.err_clr;

  lfsr_checker #(.N(8), .LOCK_THR(16), .LOSS_THR(8), .ERR_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  lfsr_checker #(.N(8), .LOCK_THR(16), .LOSS_THR(8), .ERR_W(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .link (link4)
  );

  logic [10:3] mn_din;
  logic        mn_valid;
  logic [10:3] mn_locked;
  logic [15:0] mn_cnt [3:10];

  for (genvar g = 3; g <= 10; g++) begin : g_n
    lfsr_checker_if #(.ERR_W(16)) lk ();
    assign lk.din       = mn_din[g];
    assign lk.din_valid = mn_valid;
    assign lk.err_clr   = 1'b0;
    assign mn_locked[g] = lk.locked;
    assign mn_cnt[g]    = lk.err_cnt;
    lfsr_checker #(.N(g), .LOCK_THR(16), .LOSS_THR(8), .ERR_W(16)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .link (lk)
    );
  end

  typedef struct packed {
    logic        err;
    logic        lock;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic [31:0] bits;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  g8;
  logic [9:0]  gs [3:10];
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  logic [31:0] nbits;
  logic        last_lock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent generator: new LSB = XNOR of the tap bits, register shifts left.
  function automatic logic gen_fb(input logic [9:0] s, input int n);
    case (n)
      3:       return ~(s[2] ^ s[1]);
      4:       return ~(s[3] ^ s[2]);
      5:       return ~(s[4] ^ s[2]);
      6:       return ~(s[5] ^ s[4]);
      7:       return ~(s[6] ^ s[5]);
      8:       return ~(s[7] ^ s[5] ^ s[4] ^ s[3]);
      9:       return ~(s[8] ^ s[4]);
      10:      return ~(s[9] ^ s[6]);
      default: return 1'b0;
    endcase
  endfunction

  // mode: 0 clean, 1 inverted generator bit, 2 stuck 0, 3 stuck 1
  task automatic drive(input logic valid, input int mode, input logic clr, input logic exp_lock);
    exp_t e;
    logic b;
    logic e_err;
    @(negedge clk);
    b = 1'($urandom_range(0, 1));
    if (valid) begin
      case (mode)
        2: b = 1'b0;
        3: b = 1'b1;
        default: begin
          b  = gen_fb(g8, 8);
          g8 = {g8[8:0], b};
          if (mode == 1) b = ~b;
        end
      endcase
    end
    e_err = valid && (mode == 1) && last_lock;
    if (clr) begin
      cnt16 = '0;
      cnt4  = '0;
      nbits = '0;
    end else begin
      if (e_err) begin
        if (cnt16 != 16'hFFFF) cnt16 = cnt16 + 16'd1;
        if (cnt4 != 4'hF) cnt4 = cnt4 + 4'd1;
      end
      if (valid && last_lock && nbits != 32'hFFFF_FFFF) nbits = nbits + 32'd1;
    end
    last_lock = exp_lock;
    e.err  = e_err;
    e.lock = exp_lock;
    e.cnt  = cnt16;
    e.cnt4 = cnt4;
    e.bits = nbits;
    sb.push_back(e);
    link.din       = b;
    link.din_valid = valid;
    link.err_clr   = clr;
    @(posedge clk);
    #2;
    link.din_valid = 1'b0;
    link.err_clr   = 1'b0;
  endtask

  always begin
    @(posedge clk);
    if (sb.size() != 0) begin
      #1;
      mon_e = sb.pop_front();
      chk("err",      32'(link.err),      32'(mon_e.err));
      chk("locked",   32'(link.locked),   32'(mon_e.lock));
      chk("err_cnt",  32'(link.err_cnt),  32'(mon_e.cnt));
      chk("err4",     32'(link4.err),     32'(mon_e.err));
      chk("locked4",  32'(link4.locked),  32'(mon_e.lock));
      chk("err_cnt4", 32'(link4.err_cnt), 32'(mon_e.cnt4));
`ifdef LFSR_CHK_BITCNT_EN
      chk("bit_cnt",  link.bit_cnt,       mon_e.bits);
`endif
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_locked",   32'(link.locked),   32'd0);
    chk("rst_err",      32'(link.err),      32'd0);
    chk("rst_err_cnt",  32'(link.err_cnt),  32'd0);
    chk("rst_err_cnt4", 32'(link4.err_cnt), 32'd0);
`ifdef LFSR_CHK_BITCNT_EN
    chk("rst_bit_cnt",  link.bit_cnt,       32'd0);
`endif
    repeat (2) @(negedge clk);
    rst       = 1'b1;
    g8        = 10'd1;
    cnt16     = '0;
    cnt4      = '0;
    nbits     = '0;
    last_lock = 1'b0;
    for (int n = 3; n <= 10; n++) gs[n] = 10'd1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int    nv;
    logic  fb;
    string tag;
    link.din       = 1'b0;
    link.din_valid = 1'b0;
    link.err_clr   = 1'b0;
    mn_valid       = 1'b0;
    mn_din         = '0;
    #2;
    do_reset();

    // Clean stream with one inverted bit well after lock.
    for (int k = 0; k < 1000; k++) drive(1'b1, (k == 123) ? 1 : 0, 1'b0, k >= 23);
    // Clear on an error cycle: pulse still seen, count cleared.
    drive(1'b1, 1, 1'b1, 1'b1);
    // Twenty isolated errors: 16-bit counter reaches 20, 4-bit one saturates at 15.
    for (int k = 0; k < 60; k++) drive(1'b1, (k % 3 == 0) ? 1 : 0, 1'b0, 1'b1);
    drive(1'b1, 0, 1'b1, 1'b1);
    // Eight consecutive errors drop lock, then a clean stream relocks.
    for (int k = 0; k < 8; k++) drive(1'b1, 1, 1'b0, k < 7);
    for (int k = 0; k < 30; k++) drive(1'b1, 0, 1'b0, k >= 23);

    // Qualifier toggling every cycle.
    do_reset();
    nv = 0;
    for (int k = 0; k < 60; k++) begin
      if (k % 2 == 0) begin
        drive(1'b1, 0, 1'b0, nv >= 23);
        nv++;
      end else begin
        drive(1'b0, 0, 1'b0, nv >= 24);
      end
    end

    // Stuck lines never lock.
    do_reset();
    for (int k = 0; k < 100; k++) drive(1'b1, 3, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 100; k++) drive(1'b1, 2, 1'b0, 1'b0);

    // Asynchronous reset while locked with errors counted.
    do_reset();
    for (int k = 0; k < 50; k++) drive(1'b1, (k == 40 || k == 45) ? 1 : 0, 1'b0, k >= 23);
    chk("pre_rst_locked",  32'(link.locked),  32'd1);
    chk("pre_rst_err_cnt", 32'(link.err_cnt), 32'd2);
    do_reset();

    // Every supported length locks on a clean stream after N+16 bits.
    for (int b = 0; b < 60; b++) begin
      @(negedge clk);
      for (int n = 3; n <= 10; n++) begin
        fb        = gen_fb(gs[n], n);
        gs[n]     = {gs[n][8:0], fb};
        mn_din[n] = fb;
      end
      mn_valid = 1'b1;
      @(posedge clk);
      #2;
      mn_valid = 1'b0;
      for (int n = 3; n <= 10; n++) begin
        if (b + 1 == n + 15) begin
          tag = $sformatf("n%0d_not_yet_locked", n);
          chk(tag, 32'(mn_locked[n]), 32'd0);
        end
        if (b + 1 == n + 16) begin
          tag = $sformatf("n%0d_locked", n);
          chk(tag, 32'(mn_locked[n]), 32'd1);
        end
      end
    end
    for (int n = 3; n <= 10; n++) begin
      tag = $sformatf("n%0d_final_locked", n);
      chk(tag, 32'(mn_locked[n]), 32'd1);
      tag = $sformatf("n%0d_err_cnt", n);
      chk(tag, 32'(mn_cnt[n]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
